// File: rtl/shortcut_pkg.sv
// Types and constants shared by the MobileNetV3 shortcut-path streaming blocks.
package shortcut_pkg;

  localparam int N = 16;  // Q8.8 element width
  localparam int Q = 8;   // fractional bits of the element format

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT,
    WAIT,
    DONE
  } state_t;

  function automatic int depth(input int feature_size, input int in_channels);
    return feature_size * feature_size * in_channels;
  endfunction

  // Index width that never collapses to zero bits for tiny configurations.
  function automatic int idx_w(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Single-port feature-map buffer: synchronous write, registered read (1-cycle latency).
module fmap_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 7840,
  parameter int AW     = 13
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [AW-1:0]            addr,
  input  logic signed [DATA_W-1:0] wdata,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pw_feature_streamer.sv
// Streams a buffered feature map into pointwise_conv, pixel-major / channel-minor,
// one beat every GAP+2 cycles, followed by a single-cycle done pulse.
module pw_feature_streamer
  import shortcut_pkg::*;
#(
  parameter int N            = shortcut_pkg::N,
  parameter int IN_CHANNELS  = 40,
  parameter int FEATURE_SIZE = 14,
  parameter int GAP          = 1,
  localparam int DEPTH  = depth(FEATURE_SIZE, IN_CHANNELS),
  localparam int PIXELS = FEATURE_SIZE * FEATURE_SIZE,
  localparam int AW     = idx_w(DEPTH),
  localparam int CW     = idx_w(IN_CHANNELS),
  localparam int PW     = idx_w(PIXELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [N-1:0] wr_data,
  input  logic                start,
  output logic signed [N-1:0] data_out,
  output logic [CW-1:0]       channel_out,
  output logic [PW-1:0]       pixel_out,
  output logic                valid_out,
  output logic                busy,
  output logic                done
);

  localparam int GW = idx_w(GAP + 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(IN_CHANNELS - 1);
  localparam logic [PW-1:0] LAST_PX  = PW'(PIXELS - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t              state;
  logic [AW-1:0]       addr_cnt;
  logic [CW-1:0]       ch_cnt;
  logic [PW-1:0]       px_cnt;
  logic [GW-1:0]       gap_cnt;
  logic                rdata_vld_p1;
  logic signed [N-1:0] rdata_p1;
  logic                ram_we;
  logic                ram_re;
  logic [AW-1:0]       ram_addr;
  logic                last_elem;

  // The buffer is shared: host writes in IDLE, streaming reads otherwise.
  assign ram_we    = wr_en && (state == IDLE);
  assign ram_re    = en && (state == FETCH);
  assign ram_addr  = (state == IDLE) ? wr_addr : addr_cnt;
  assign last_elem = (ch_cnt == LAST_CH) && (px_cnt == LAST_PX);

  // p0 -> p1: address presented in FETCH, word available during EMIT
  fmap_ram #(
    .DATA_W (N),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_fmap_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (rdata_p1)
  );

  // RAM output is not reset, so it is masked until the first fetch lands.
  assign data_out  = rdata_vld_p1 ? rdata_p1 : '0;
  assign valid_out = en && (state == EMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      ch_cnt       <= '0;
      px_cnt       <= '0;
      gap_cnt      <= '0;
      channel_out  <= '0;
      pixel_out    <= '0;
      rdata_vld_p1 <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (state == IDLE) begin
      if (start && en) begin
        state    <= FETCH;
        addr_cnt <= '0;
        ch_cnt   <= '0;
        px_cnt   <= '0;
        gap_cnt  <= '0;
        busy     <= 1'b1;
      end
    end else if (en) begin
      case (state)
        FETCH: begin
          state        <= EMIT;
          channel_out  <= ch_cnt;
          pixel_out    <= px_cnt;
          rdata_vld_p1 <= 1'b1;
        end
        EMIT: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (ch_cnt == LAST_CH) begin
            ch_cnt <= '0;
            px_cnt <= px_cnt + 1'b1;
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
          end
          if (last_elem) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (GAP == 0) begin
            state <= FETCH;
          end else begin
            state   <= WAIT;
            gap_cnt <= '0;
          end
        end
        WAIT: begin
          if (gap_cnt == LAST_GAP) state <= FETCH;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pw_feature_streamer.sv
// Scoreboard bench for pw_feature_streamer: default map plus a tiny 2x2x3 GAP=0 instance.
module tb_pw_feature_streamer;

  localparam int BIG_D = 7840;
  localparam int SM_D  = 12;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  ch;
    logic [7:0]  px;
    int          cyc;
  } beat_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  // default-configuration instance
  logic        en, wr_en, start;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] data_out;
  logic [5:0]  channel_out;
  logic [7:0]  pixel_out;
  logic        valid_out, busy, done;

  // small-configuration instance
  logic        s_en, s_wr_en, s_start;
  logic [3:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic [15:0] s_data_out;
  logic [1:0]  s_channel_out;
  logic [1:0]  s_pixel_out;
  logic        s_valid_out, s_busy, s_done;

  beat_t big_q[$];
  beat_t small_q[$];
  int    big_done_q[$];
  int    small_done_q[$];
  int    big_done_n = 0;
  int    small_done_n = 0;

  pw_feature_streamer dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .data_out(data_out), .channel_out(channel_out), .pixel_out(pixel_out),
    .valid_out(valid_out), .busy(busy), .done(done)
  );

  pw_feature_streamer #(.N(16), .IN_CHANNELS(3), .FEATURE_SIZE(2), .GAP(0)) dut_small (
    .clk(clk), .rst(rst), .en(s_en), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .start(s_start), .data_out(s_data_out), .channel_out(s_channel_out),
    .pixel_out(s_pixel_out), .valid_out(s_valid_out), .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got output %0d with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_big(input int s, input int last, input int stall_beat, input int stall_len);
    beat_t b;
    for (int k = 0; k <= last; k++) begin
      b.data = 16'(k);
      b.ch   = 8'(k % 40);
      b.px   = 8'(k / 40);
      b.cyc  = s + 1 + 3 * k + ((k >= stall_beat) ? stall_len : 0);
      big_q.push_back(b);
    end
  endtask

  task automatic push_small(input int s);
    beat_t b;
    for (int k = 0; k < SM_D; k++) begin
      b.data = 16'h0A00 + 16'(k);
      b.ch   = 8'(k % 3);
      b.px   = 8'(k / 3);
      b.cyc  = s + 1 + 2 * k;
      small_q.push_back(b);
    end
    small_done_q.push_back(s + 24);
  endtask

  task automatic wait_big_done(input int target, input int budget);
    int n = 0;
    while (big_done_n < target && n < budget) begin
      tick();
      n++;
    end
    chk("big_done_count", 64'(big_done_n), 64'(target));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},    64'(data_out),    64'd0);
    chk({tag, "_channel"}, 64'(channel_out), 64'd0);
    chk({tag, "_pixel"},   64'(pixel_out),   64'd0);
    chk({tag, "_valid"},   64'(valid_out),   64'd0);
    chk({tag, "_busy"},    64'(busy),        64'd0);
    chk({tag, "_done"},    64'(done),        64'd0);
  endtask

  // monitor: default instance
  initial forever begin
    beat_t bb;
    int    de;
    @(negedge clk);
    if (valid_out) begin
      if (big_q.size() == 0) unexpected("big_beat", 64'(data_out));
      else begin
        bb = big_q.pop_front();
        chk("big_data",    64'(data_out),    64'(bb.data));
        chk("big_channel", 64'(channel_out), 64'(bb.ch));
        chk("big_pixel",   64'(pixel_out),   64'(bb.px));
        chk("big_cycle",   64'(cyc),         64'(bb.cyc));
        chk("big_busy_in_beat", 64'(busy),   64'd1);
      end
    end
    if (done) begin
      big_done_n++;
      if (big_done_q.size() == 0) unexpected("big_done", 64'(cyc));
      else begin
        de = big_done_q.pop_front();
        chk("big_done_cycle", 64'(cyc), 64'(de));
        chk("big_busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // monitor: small instance
  initial forever begin
    beat_t sb;
    int    de;
    @(negedge clk);
    if (s_valid_out) begin
      if (small_q.size() == 0) unexpected("small_beat", 64'(s_data_out));
      else begin
        sb = small_q.pop_front();
        chk("small_data",    64'(s_data_out),    64'(sb.data));
        chk("small_channel", 64'(s_channel_out), 64'(sb.ch));
        chk("small_pixel",   64'(s_pixel_out),   64'(sb.px));
        chk("small_cycle",   64'(cyc),           64'(sb.cyc));
      end
    end
    if (s_done) begin
      small_done_n++;
      if (small_done_q.size() == 0) unexpected("small_done", 64'(cyc));
      else begin
        de = small_done_q.pop_front();
        chk("small_done_cycle", 64'(cyc), 64'(de));
        chk("small_busy_at_done", 64'(s_busy), 64'd0);
      end
    end
  end

  initial begin
    int s;
    rst = 1'b0;
    en = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0;
    s_en = 1'b1; s_wr_en = 1'b0; s_start = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    repeat (3) tick();

    check_all_zero("reset");
    chk("reset_s_data",    64'(s_data_out),    64'd0);
    chk("reset_s_channel", 64'(s_channel_out), 64'd0);
    chk("reset_s_pixel",   64'(s_pixel_out),   64'd0);
    chk("reset_s_valid",   64'(s_valid_out),   64'd0);
    chk("reset_s_busy",    64'(s_busy),        64'd0);
    chk("reset_s_done",    64'(s_done),        64'd0);
    rst = 1'b1;
    tick();

    // small map, start held high through DONE for a back-to-back second run
    for (int k = 0; k < SM_D; k++) begin
      s_wr_en = 1'b1; s_wr_addr = 4'(k); s_wr_data = 16'h0A00 + 16'(k);
      tick();
    end
    s_wr_en = 1'b0;
    s_start = 1'b1;
    s = cyc + 1;
    push_small(s);
    push_small(s + 26);
    repeat (28) tick();
    s_start = 1'b0;
    for (int n = 0; n < 200 && small_done_n < 2; n++) tick();
    chk("small_done_pulses", 64'(small_done_n), 64'd2);
    chk("small_q_drained", 64'(small_q.size()), 64'd0);

    // load default map with mem[k] = k
    for (int k = 0; k < BIG_D; k++) begin
      wr_en = 1'b1; wr_addr = 13'(k); wr_data = 16'(k);
      tick();
    end
    wr_en = 1'b0;

    // full stream
    start = 1'b1;
    s = cyc + 1;
    push_big(s, BIG_D - 1, BIG_D, 0);
    big_done_q.push_back(s + 23519);
    tick();
    start = 1'b0;
    wait_big_done(1, 24000);
    chk("run1_q_drained", 64'(big_q.size()), 64'd0);

    // stall on beat 100, then illegal start/write mid-stream
    tick();
    start = 1'b1;
    s = cyc + 1;
    push_big(s, BIG_D - 1, 100, 5);
    big_done_q.push_back(s + 23519 + 5);
    tick();
    start = 1'b0;
    while (cyc < s + 301) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    while (cyc < s + 700) tick();
    start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 16'hFFFF;
    repeat (3) tick();
    start = 1'b0; wr_en = 1'b0;
    wait_big_done(2, 24000);
    chk("run2_q_drained", 64'(big_q.size()), 64'd0);

    // reset while beat 500 is on the outputs
    tick();
    start = 1'b1;
    s = cyc + 1;
    push_big(s, 499, BIG_D, 0);
    tick();
    start = 1'b0;
    while (cyc < s + 1501) tick();
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    rst = 1'b1;
    chk("run3_q_drained", 64'(big_q.size()), 64'd0);

    // restart after reset: stream begins again at element 0
    tick();
    start = 1'b1;
    s = cyc + 1;
    push_big(s, 9, BIG_D, 0);
    tick();
    start = 1'b0;
    while (cyc < s + 30) tick();
    chk("run4_q_drained", 64'(big_q.size()), 64'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("big_done_total", 64'(big_done_n), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
